// File: rtl/test_status_pkg.sv
// Shared constants and types for the memory-mapped test-status responder.
package test_status_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OFF_W  = 4;

  localparam logic [OFF_W-1:0] OFF_STATUS  = 4'h0;
  localparam logic [OFF_W-1:0] OFF_CONSOLE = 4'h4;
  localparam logic [OFF_W-1:0] OFF_CYCLE   = 4'h8;
  localparam logic [OFF_W-1:0] OFF_INSTRET = 4'hC;

  localparam logic [DATA_W-1:0] DEFAULT_PASS_CODE = 32'hC0DE_CAFE;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } status_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, no bypass; a push into a full FIFO is accepted only when a pop frees a slot.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/test_status_mmio.sv
// Test-status MMIO responder: address decode, pass/fail/timeout FSM, counters and console FIFO.
module test_status_mmio
  import test_status_pkg::*;
#(
  parameter logic [31:0] BASE           = 32'h0000_0100,
  parameter logic [31:0] PASS_CODE      = DEFAULT_PASS_CODE,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              sel,
  input  logic              retire,
  output logic              con_valid,
  input  logic              con_ready,
  output logic [7:0]        con_data,
  output logic              done,
  output logic              pass,
  output logic              timeout
);

  status_state_t     state_q, state_d;
  logic [DATA_W-1:0] status_q, status_d;
  logic [DATA_W-1:0] cycle_q, cycle_d;
  logic [DATA_W-1:0] instret_q, instret_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              sel_q, done_q, pass_q, timeout_q;
  logic              overflow_q, overflow_d, misalign_q, misalign_d;

  logic             in_window, aligned, hit;
  logic [OFF_W-1:0] off;
  logic             wr_status, wr_console, rd_hit;
  logic             fifo_full, fifo_empty, fifo_pop;

  assign in_window  = (addr[31:4] == BASE[31:4]);
  assign aligned    = (addr[1:0] == 2'b00);
  assign hit        = in_window && aligned;
  assign off        = addr[OFF_W-1:0];
  assign wr_status  = mem_write && hit && (off == OFF_STATUS);
  assign wr_console = mem_write && hit && (off == OFF_CONSOLE);
  assign rd_hit     = mem_read && hit;
  assign fifo_pop   = !fifo_empty && con_ready;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_con_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_console),
    .pop   (fifo_pop),
    .din   (wdata[7:0]),
    .dout  (con_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    rdata_d    = '0;
    overflow_d = overflow_q | (wr_console && fifo_full && !fifo_pop);
    misalign_d = misalign_q | (mem_write && in_window && !aligned);

    // A deciding STATUS write beats the timeout; a zero write leaves the run going.
    if (state_q == ST_RUN) begin
      if (wr_status) status_d = wdata;
      if (wr_status && (wdata != '0)) begin
        state_d = (wdata == PASS_CODE) ? ST_PASS : ST_FAIL;
      end else if (cycle_q == DATA_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = ST_TIMEOUT;
      end
    end

    // The deciding cycle is not counted, so CYCLE freezes at the cycle of the decision.
    cycle_d   = (state_d == ST_RUN) ? cycle_q + DATA_W'(1) : cycle_q;
    instret_d = ((state_q == ST_RUN) && retire) ? instret_q + DATA_W'(1) : instret_q;

    if (rd_hit) begin
      case (off)
        OFF_STATUS:  rdata_d = status_q;
        OFF_CONSOLE: rdata_d = DATA_W'({misalign_q, overflow_q, fifo_full, fifo_empty});
        OFF_CYCLE:   rdata_d = cycle_q;
        OFF_INSTRET: rdata_d = instret_q;
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      status_q   <= '0;
      cycle_q    <= '0;
      instret_q  <= '0;
      rdata_q    <= '0;
      sel_q      <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      cycle_q    <= cycle_d;
      instret_q  <= instret_d;
      rdata_q    <= rdata_d;
      sel_q      <= rd_hit;
      done_q     <= (state_d != ST_RUN);
      pass_q     <= (state_d == ST_PASS);
      timeout_q  <= (state_d == ST_TIMEOUT);
      overflow_q <= overflow_d;
      misalign_q <= misalign_d;
    end
  end

  assign rdata     = rdata_q;
  assign sel       = sel_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign timeout   = timeout_q;
  assign con_valid = !fifo_empty;

endmodule

// File: doc/test_status_mmio.md
# test_status_mmio

Memory-mapped test-status responder on the CPU data-memory bus. It is the device side of the pass/fail handshake: programs store a status code, push console bytes and read cycle/instret counters. The block turns those stores into registered `done`/`pass`/`timeout` outputs and a byte stream for the bench. It sits beside the data memory and decodes its own address window; it never drives data-memory writes.

## Interface
Parameters:
- `BASE`, 32'h0000_0100, word-aligned base of the 16-byte register window.
- `PASS_CODE`, 32'hC0DE_CAFE, status value that means pass.
- `TIMEOUT_CYCLES`, 1000, number of RUN cycles before forced timeout (≥2).
- `FIFO_DEPTH`, 4, console FIFO entries (power of two, ≥2).

Ports:
- `clk` in 1, clock; all logic on the rising edge.
- `reset` in 1, synchronous, active-low.
- `mem_write` in 1, store strobe from the datapath.
- `mem_read` in 1, load strobe.
- `addr` in 32, byte address.
- `wdata` in 32, store data (rs2).
- `rdata` out 32, load data, registered.
- `sel` out 1, registered; high when the previous-cycle load hit the window.
- `retire` in 1, one pulse per retired instruction.
- `con_valid` out 1, console byte available.
- `con_ready` in 1, bench accepts the byte.
- `con_data` out 8, console byte.
- `done` out 1, terminal state reached.
- `pass` out 1, PASS reached.
- `timeout` out 1, TIMEOUT reached.

## Operation
- A hit is `addr[31:4] == BASE[31:4]` with `addr[1:0] == 0`. Misaligned accesses are ignored. A misaligned write sets sticky `misalign`.
- Register map (offset, access):
  - 0x0 STATUS: W stores the code; R returns the last code (reset 0).
  - 0x4 CONSOLE: W pushes `wdata[7:0]`; R returns `{28'b0, misalign, overflow, full, empty}`.
  - 0x8 CYCLE: R only; RUN-cycle count.
  - 0xC INSTRET: R only; retire count.
- Writes to read-only offsets are ignored.
- FSM states: RUN, PASS, FAIL, TIMEOUT. Reset enters RUN.
  - RUN, STATUS write == PASS_CODE -> PASS.
  - RUN, STATUS write nonzero and != PASS_CODE -> FAIL.
  - RUN, STATUS write of 0 -> ignored, stays RUN.
  - RUN, CYCLE == TIMEOUT_CYCLES-1 with no STATUS write that cycle -> TIMEOUT.
  - STATUS write on the timeout cycle: the write wins.
  - PASS, FAIL and TIMEOUT hold until reset. Later STATUS writes are ignored, and the STATUS register is not updated.
- Counters increment only in RUN and freeze in terminal states. They are 32-bit and wrap.
- Console FIFO behaviour:
  - Push when not full.
  - A push while full is dropped and sets sticky `overflow`.
  - Push and pop in the same cycle while full are both accepted; count is unchanged.
  - There is no bypass path. `con_valid` = !empty. Pop on `con_valid && con_ready`.
  - Pushes are accepted in every state.

## Timing
- Reset values: rdata 0, sel 0, con_valid 0, con_data 0, done 0, pass 0, timeout 0, all counters 0, FIFO empty, sticky bits 0.
- Load latency is 1 cycle: `rdata`/`sel` are valid the cycle after `mem_read`. On a miss, `rdata` is 0.
- A read of CYCLE returns the value before that cycle's increment.
- `done`/`pass`/`timeout` rise the cycle after the deciding write or the timeout cycle. `done` = pass|fail|timeout.
- A pushed byte appears on `con_valid` the cycle after the write. `con_data` stays stable while `con_valid && !con_ready`.
- `mem_read` and `mem_write` on the same cycle: the write takes effect, and the read returns pre-write state.
- Reset mid-operation clears everything next edge, including FIFO contents and terminal state.

## Structure
- Package `test_status_pkg`:
  - offsets `OFF_STATUS`/`OFF_CONSOLE`/`OFF_CYCLE`/`OFF_INSTRET`;
  - state typedef `status_state_t`;
  - default `PASS_CODE`.
- Sub-module `sync_fifo` (params WIDTH, DEPTH):
  - ports: push, pop, din, dout, full, empty;
  - count uses DEPTH width+1.
- Top module holds the decoder, FSM, counters, sticky bits and read mux.

## Test plan
- Write 0xC0DE_CAFE to BASE+0 at cycle 10 -> done=pass=1 at cycle 11, timeout=0. CYCLE reads 10 afterwards and stays frozen.
- Write 0x0000_0001 to BASE+0 -> done=1, pass=0. A subsequent PASS_CODE write leaves pass=0, and STATUS reads 1.
- No writes, TIMEOUT_CYCLES=20 -> timeout=done=1 exactly 20 cycles after reset release. PASS_CODE written on cycle 19 -> pass=1, timeout=0.
- Console stall test:
  - stimulus: push 'O','K','\n' with con_ready=0 for 5 cycles, then 1;
  - required: bytes 0x4F, 0x4B, 0x0A in order, con_data stable while stalled, CONSOLE status reads empty=1 afterwards.
- Console overflow test:
  - stimulus: FIFO_DEPTH=4, push 6 bytes with con_ready=0;
  - required: full=1 and overflow=1; drained order is the first 4 bytes only.
- Counter and reset test:
  - stimulus: 7 retire pulses, then read BASE+0xC;
  - required: rdata=7, sel=1 one cycle later;
  - then: reset low one cycle mid-stream -> all outputs 0 and FIFO empty next cycle.
